vga: RTL and testbench



---
 rtl/vga_pkg.sv | 54 +++++
 rtl/vga_timing.sv | 82 ++++++++
 rtl/vga.sv | 74 +++++++
 tb/tb_vga.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, colour-bar palette and sync-window helper for the VGA
// test-pattern generator.
package vga_pkg;

  localparam int unsigned DEF_PIXEL_BITS  = 4;
  localparam int unsigned DEF_CLK_DIV     = 2;
  localparam int unsigned DEF_H_COUNT_MAX = 800;
  localparam int unsigned DEF_V_COUNT_MAX = 525;
  localparam int unsigned DEF_H_ACTIVE    = 640;
  localparam int unsigned DEF_H_FP        = 16;
  localparam int unsigned DEF_H_SYNC      = 96;
  localparam int unsigned DEF_V_ACTIVE    = 480;
  localparam int unsigned DEF_V_FP        = 10;
  localparam int unsigned DEF_V_SYNC      = 2;

  // Bar colours as {R,G,B} enables.
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  // Sync pulse occupies [lo, hi) in counter units.
  typedef struct packed {
    int unsigned lo;
    int unsigned hi;
  } sync_win_t;

  function automatic sync_win_t sync_window(input int unsigned active,
                                            input int unsigned front_porch,
                                            input int unsigned width);
    sync_win_t w;
    w.lo = active + front_porch;
    w.hi = active + front_porch + width;
    return w;
  endfunction

  function automatic logic [2:0] bar_colour(input logic [2:0] bar);
    case (bar)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider, horizontal/vertical counters and combinational
// sync/active decode for the VGA generator.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter int unsigned H_COUNT_MAX = DEF_H_COUNT_MAX,
  parameter int unsigned V_COUNT_MAX = DEF_V_COUNT_MAX,
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  localparam int unsigned H_BITS     = $clog2(H_COUNT_MAX),
  localparam int unsigned V_BITS     = $clog2(V_COUNT_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [H_BITS-1:0] h_cnt,
  output logic [V_BITS-1:0] v_cnt,
  output logic              active,
  output logic              h_sync,
  output logic              v_sync
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing: CLK_DIV must be at least 1");
  end
  if (H_ACTIVE + H_FP + H_SYNC >= H_COUNT_MAX) begin : g_bad_h
    $error("vga_timing: horizontal timing does not fit in H_COUNT_MAX");
  end
  if (V_ACTIVE + V_FP + V_SYNC >= V_COUNT_MAX) begin : g_bad_v
    $error("vga_timing: vertical timing does not fit in V_COUNT_MAX");
  end

  localparam int unsigned DIV_BITS = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam sync_win_t   H_WIN    = sync_window(H_ACTIVE, H_FP, H_SYNC);
  localparam sync_win_t   V_WIN    = sync_window(V_ACTIVE, V_FP, V_SYNC);

  localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(CLK_DIV - 1);
  localparam logic [H_BITS-1:0]   H_LAST   = H_BITS'(H_COUNT_MAX - 1);
  localparam logic [V_BITS-1:0]   V_LAST   = V_BITS'(V_COUNT_MAX - 1);
  localparam logic [H_BITS-1:0]   H_ACT    = H_BITS'(H_ACTIVE);
  localparam logic [V_BITS-1:0]   V_ACT    = V_BITS'(V_ACTIVE);
  localparam logic [H_BITS-1:0]   HS_LO    = H_BITS'(H_WIN.lo);
  localparam logic [H_BITS-1:0]   HS_HI    = H_BITS'(H_WIN.hi);
  localparam logic [V_BITS-1:0]   VS_LO    = V_BITS'(V_WIN.lo);
  localparam logic [V_BITS-1:0]   VS_HI    = V_BITS'(V_WIN.hi);

  logic [DIV_BITS-1:0] div_cnt;
  logic                pix_en;

  // With CLK_DIV=1 the divider sits at 0 and pix_en is permanently high.
  assign pix_en = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      if (pix_en) div_cnt <= '0;
      else        div_cnt <= div_cnt + 1'b1;

      if (pix_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          if (v_cnt == V_LAST) v_cnt <= '0;
          else                 v_cnt <= v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign h_sync = !((h_cnt >= HS_LO) && (h_cnt < HS_HI));
  assign v_sync = !((v_cnt >= VS_LO) && (v_cnt < VS_HI));

endmodule

// File: rtl/vga.sv
// VGA timing generator with an eight-bar colour test pattern.
// Define VGA_BORDER_EN to draw a one-pixel white frame around the visible area.
module vga
  import vga_pkg::*;
#(
  parameter int unsigned PIXEL_BITS  = DEF_PIXEL_BITS,
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter int unsigned H_COUNT_MAX = DEF_H_COUNT_MAX,
  parameter int unsigned V_COUNT_MAX = DEF_V_COUNT_MAX,
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  localparam int unsigned H_BITS     = $clog2(H_COUNT_MAX),
  localparam int unsigned V_BITS     = $clog2(V_COUNT_MAX)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [PIXEL_BITS-1:0] vga_r,
  output logic [PIXEL_BITS-1:0] vga_g,
  output logic [PIXEL_BITS-1:0] vga_b,
  output logic                  h_sync,
  output logic                  v_sync,
  output logic [H_BITS-1:0]     vga_x,
  output logic [V_BITS-1:0]     vga_y,
  output logic                  vga_active
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;

  vga_timing #(
    .CLK_DIV     (CLK_DIV),
    .H_COUNT_MAX (H_COUNT_MAX),
    .V_COUNT_MAX (V_COUNT_MAX),
    .H_ACTIVE    (H_ACTIVE),
    .H_FP        (H_FP),
    .H_SYNC      (H_SYNC),
    .V_ACTIVE    (V_ACTIVE),
    .V_FP        (V_FP),
    .V_SYNC      (V_SYNC)
  ) u_timing (
    .clk    (clk),
    .rst    (rst),
    .h_cnt  (vga_x),
    .v_cnt  (vga_y),
    .active (vga_active),
    .h_sync (h_sync),
    .v_sync (v_sync)
  );

  logic [2:0] bar;
  logic [2:0] rgb_en;

  // Bar index by threshold compare instead of dividing by a non-power-of-two width.
  always_comb begin
    bar = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (vga_x >= H_BITS'(k * BAR_W)) bar = 3'(k);
    end
    rgb_en = bar_colour(bar);
`ifdef VGA_BORDER_EN
    if (vga_x == '0 || vga_x == H_BITS'(H_ACTIVE - 1) ||
        vga_y == '0 || vga_y == V_BITS'(V_ACTIVE - 1)) begin
      rgb_en = '1;
    end
`endif
    vga_r = (vga_active && rgb_en[2]) ? '1 : '0;
    vga_g = (vga_active && rgb_en[1]) ? '1 : '0;
    vga_b = (vga_active && rgb_en[0]) ? '1 : '0;
  end

endmodule

// File: tb/tb_vga.sv
// Self-checking bench for vga: reduced timing, an elapsed-clock reference model,
// literal spot checks and randomized asynchronous resets.
module tb_vga;

  localparam int PB    = 4;
  localparam int DIV   = 3;
  localparam int HM    = 40;
  localparam int VM    = 20;
  localparam int HA    = 24;
  localparam int HF    = 4;
  localparam int HS    = 6;
  localparam int VA    = 12;
  localparam int VF    = 2;
  localparam int VS    = 2;
  localparam int HB    = $clog2(HM);
  localparam int VB    = $clog2(VM);
  localparam int FULL  = (1 << PB) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PB-1:0] vga_r, vga_g, vga_b;
  logic          h_sync, v_sync, vga_active;
  logic [HB-1:0] vga_x;
  logic [VB-1:0] vga_y;

  int n_checks = 0;
  int n_fail   = 0;
  int n_clk    = 0;

  vga #(
    .PIXEL_BITS  (PB),
    .CLK_DIV     (DIV),
    .H_COUNT_MAX (HM),
    .V_COUNT_MAX (VM),
    .H_ACTIVE    (HA),
    .H_FP        (HF),
    .H_SYNC      (HS),
    .V_ACTIVE    (VA),
    .V_FP        (VF),
    .V_SYNC      (VS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_active (vga_active)
  );

  always #5 clk = ~clk;

  // Rising edges seen since the last reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) n_clk <= 0;
    else      n_clk <= n_clk + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Screen position follows from elapsed pixels; outputs follow from position.
  task automatic model(input int n, output int ex, output int ey, output int ea,
                       output int ehs, output int evs, output int er,
                       output int eg, output int eb);
    int p, bar;
    bit r_on, g_on, b_on;
    p   = n / DIV;
    ex  = p % HM;
    ey  = (p / HM) % VM;
    ea  = (ex < HA && ey < VA) ? 1 : 0;
    ehs = (ex >= HA + HF && ex < HA + HF + HS) ? 0 : 1;
    evs = (ey >= VA + VF && ey < VA + VF + VS) ? 0 : 1;
    bar = ex / (HA / 8);
    r_on = (bar == 0 || bar == 1 || bar == 4 || bar == 5);
    g_on = (bar <= 3);
    b_on = (bar % 2 == 0);
`ifdef VGA_BORDER_EN
    if (ex == 0 || ex == HA - 1 || ey == 0 || ey == VA - 1) begin
      r_on = 1; g_on = 1; b_on = 1;
    end
`endif
    er = (ea == 1 && r_on) ? FULL : 0;
    eg = (ea == 1 && g_on) ? FULL : 0;
    eb = (ea == 1 && b_on) ? FULL : 0;
  endtask

  always @(negedge clk) begin
    int ex, ey, ea, ehs, evs, er, eg, eb;
    model(n_clk, ex, ey, ea, ehs, evs, er, eg, eb);
    chk("vga_x",      int'(vga_x),      ex);
    chk("vga_y",      int'(vga_y),      ey);
    chk("vga_active", int'(vga_active), ea);
    chk("h_sync",     int'(h_sync),     ehs);
    chk("v_sync",     int'(v_sync),     evs);
    chk("vga_r",      int'(vga_r),      er);
    chk("vga_g",      int'(vga_g),      eg);
    chk("vga_b",      int'(vga_b),      eb);
  end

  int cur = 0;

  task automatic advance_to(input int target);
    repeat (target - cur) @(negedge clk);
    cur = target;
  endtask

  initial begin
    #50;
    chk("rst_hold_x",      int'(vga_x),      0);
    chk("rst_hold_y",      int'(vga_y),      0);
    chk("rst_hold_active", int'(vga_active), 1);
    chk("rst_hold_hsync",  int'(h_sync),     1);
    chk("rst_hold_vsync",  int'(v_sync),     1);
    chk("rst_hold_rgb",    int'({vga_r, vga_g, vga_b}), 12'hFFF);
    #50;
    @(negedge clk);
    #1 rst = 1'b1;
    cur = 0;

    advance_to(2);    chk("pin_x_before_first_pix_en", int'(vga_x), 0);
    advance_to(3);    chk("pin_x_after_first_pix_en",  int'(vga_x), 1);
    advance_to(141);  chk("pin_cyan_x7_y1", int'({vga_r, vga_g, vga_b}), 12'h0FF);
    advance_to(201);  chk("pin_hsync_x27",  int'(h_sync), 1);
    advance_to(204);  chk("pin_hsync_x28",  int'(h_sync), 0);
                      chk("pin_rgb_blank_x28", int'({vga_r, vga_g, vga_b}), 0);
                      chk("pin_active_x28", int'(vga_active), 0);
    advance_to(219);  chk("pin_hsync_x33",  int'(h_sync), 0);
    advance_to(222);  chk("pin_hsync_x34",  int'(h_sync), 1);
    advance_to(1680); chk("pin_vsync_y14",  int'(v_sync), 0);
    advance_to(1920); chk("pin_vsync_y16",  int'(v_sync), 1);
    advance_to(2399); chk("pin_end_x39",    int'(vga_x), 39);
                      chk("pin_end_y19",    int'(vga_y), 19);
    advance_to(2400); chk("pin_wrap_x",     int'(vga_x), 0);
                      chk("pin_wrap_y",     int'(vga_y), 0);
    advance_to(2400 + 2 * HM * VM * DIV);

    repeat (8) begin
      repeat ($urandom_range(100, 3000)) @(negedge clk);
      @(posedge clk);
      #($urandom_range(1, 3));
      rst = 1'b0;
      #1;
      chk("async_rst_x",      int'(vga_x),      0);
      chk("async_rst_y",      int'(vga_y),      0);
      chk("async_rst_active", int'(vga_active), 1);
      chk("async_rst_hsync",  int'(h_sync),     1);
      chk("async_rst_rgb",    int'({vga_r, vga_g, vga_b}), 12'hFFF);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #2 rst = 1'b1;
    end
    repeat (HM * VM * DIV + 50) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
